jesd204_lmfc_gen: RTL and testbench

Generates the local multiframe clock (LMFC) timebase for a JESD204 link from the device clock and an external SYSREF.
- Captures SYSREF and aligns a beat counter to it.
- Emits a single-cycle lmfc_edge pulse per multiframe, which drives the downstream frame/multiframe marker logic (SOF/EOF/EOMF generation).
- Reports SYSREF capture status and SYSREF-to-LMFC misalignment.

---
 rtl/jesd204_lmfc_gen.sv | 100 ++++++++++
 tb/tb_jesd204_lmfc_gen.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jesd204_lmfc_gen.sv
// JESD204 LMFC timebase: SYSREF capture, LMFC counter/edge/clock, alignment status.
// Optional SYSREF statistics counters when JESD204_LMFC_SYSREF_STATS_EN is defined.
module jesd204_lmfc_gen #(
    parameter int DATA_PATH_WIDTH = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sysref,
    input  logic [CNT_W-1:0] cfg_beats_per_multiframe,
    input  logic [CNT_W-1:0] cfg_lmfc_offset,
    input  logic             cfg_sysref_oneshot,
    input  logic             cfg_sysref_disable,
    output logic             lmfc_edge,
    output logic             lmfc_clk,
    output logic [CNT_W-1:0] lmfc_counter,
    output logic             sysref_edge,
    output logic             sysref_captured,
    output logic             sysref_alignment_error
`ifdef JESD204_LMFC_SYSREF_STATS_EN
    ,
    output logic [15:0]      sysref_event_count,
    output logic [7:0]       sysref_error_count
`endif
);

    if (!(DATA_PATH_WIDTH == 4 || DATA_PATH_WIDTH == 8)) begin : g_dpw_check
        $error("jesd204_lmfc_gen: DATA_PATH_WIDTH must be 4 or 8");
    end

    logic             sysref_r;
    logic             sysref_d1;
    logic             sysref_det;
    logic             lmfc_active;
    logic             accepted;
    logic             misaligned;
    logic             active_next;
    logic [CNT_W-1:0] cnt_wrap;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] half_beats;

    assign sysref_det = sysref_r & ~sysref_d1;

    // Acceptance acts on the registered edge pulse, so the reload lands one
    // cycle after sysref_edge is visible.
    assign accepted = sysref_edge & ~cfg_sysref_disable
                    & ~(cfg_sysref_oneshot & sysref_captured);

    // >= rather than == so a counter left above a shrunken limit re-wraps at once.
    assign cnt_wrap   = (lmfc_counter >= cfg_beats_per_multiframe) ? '0
                                                                    : lmfc_counter + CNT_W'(1);
    assign load_val   = (cfg_lmfc_offset > cfg_beats_per_multiframe) ? '0 : cfg_lmfc_offset;
    assign cnt_next   = accepted ? load_val : cnt_wrap;
    assign misaligned = accepted & sysref_captured & (cnt_wrap != load_val);
    assign active_next = lmfc_active | accepted | cfg_sysref_disable;
    assign half_beats = cfg_beats_per_multiframe >> 1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sysref_r               <= 1'b0;
            sysref_d1              <= 1'b0;
            sysref_edge            <= 1'b0;
            lmfc_counter           <= '0;
            lmfc_active            <= 1'b0;
            lmfc_edge              <= 1'b0;
            lmfc_clk               <= 1'b0;
            sysref_captured        <= 1'b0;
            sysref_alignment_error <= 1'b0;
        end else begin
            sysref_r     <= sysref;
            sysref_d1    <= sysref_r;
            sysref_edge  <= sysref_det;
            lmfc_counter <= cnt_next;
            lmfc_active  <= active_next;
            // Outputs are computed from the next counter value so they line up with it.
            lmfc_edge    <= active_next & (cnt_next == '0);
            lmfc_clk     <= active_next & (cnt_next <= half_beats);
            if (accepted)
                sysref_captured <= 1'b1;
            if (misaligned)
                sysref_alignment_error <= 1'b1;
        end
    end

`ifdef JESD204_LMFC_SYSREF_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sysref_event_count <= '0;
            sysref_error_count <= '0;
        end else begin
            if (accepted && sysref_event_count != '1)
                sysref_event_count <= sysref_event_count + 16'd1;
            if (misaligned && sysref_error_count != '1)
                sysref_error_count <= sysref_error_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_jesd204_lmfc_gen.sv
// Self-checking bench for jesd204_lmfc_gen: directed scenarios plus randomized
// SYSREF traffic against a cycle-level arithmetic reference model.
module tb_jesd204_lmfc_gen;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             sysref = 1'b0;
    logic [CNT_W-1:0] beats = 8'd3;
    logic [CNT_W-1:0] off = 8'd0;
    logic             one = 1'b0;
    logic             dis = 1'b0;
    logic             lmfc_edge, lmfc_clk, sysref_edge, sysref_captured, sysref_alignment_error;
    logic [CNT_W-1:0] lmfc_counter;
`ifdef JESD204_LMFC_SYSREF_STATS_EN
    logic [15:0]      sysref_event_count;
    logic [7:0]       sysref_error_count;
`endif

    jesd204_lmfc_gen #(.DATA_PATH_WIDTH(4), .CNT_W(CNT_W)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .sysref                   (sysref),
        .cfg_beats_per_multiframe (beats),
        .cfg_lmfc_offset          (off),
        .cfg_sysref_oneshot       (one),
        .cfg_sysref_disable       (dis),
        .lmfc_edge                (lmfc_edge),
        .lmfc_clk                 (lmfc_clk),
        .lmfc_counter             (lmfc_counter),
        .sysref_edge              (sysref_edge),
        .sysref_captured          (sysref_captured),
        .sysref_alignment_error   (sysref_alignment_error)
`ifdef JESD204_LMFC_SYSREF_STATS_EN
        ,
        .sysref_event_count       (sysref_event_count),
        .sysref_error_count       (sysref_error_count)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state: values the DUT outputs should hold after each edge.
    int m_cnt, m_ev, m_er;
    bit m_active, m_cap, m_err, m_sedge;
    bit hist[$];

    logic [12:0] act_vec;
    assign act_vec = {lmfc_edge, lmfc_clk, lmfc_counter, sysref_edge,
                      sysref_captured, sysref_alignment_error};

    function automatic logic [12:0] exp_vec();
        return {m_active && (m_cnt == 0), m_active && (m_cnt <= int'(beats) / 2),
                8'(m_cnt), m_sedge, m_cap, m_err};
    endfunction

    task automatic model_clear();
        m_cnt = 0; m_ev = 0; m_er = 0;
        m_active = 0; m_cap = 0; m_err = 0; m_sedge = 0;
        hist.delete();
    endtask

    // Drive one cycle of SYSREF and advance the model by one clock edge.
    task automatic step(input bit v);
        bit acc, p1, p2;
        int b, load;
        sysref = v;
        @(posedge clk);
        b   = int'(beats);
        acc = m_sedge && !dis && !(one && m_cap);
        if (acc) begin
            load = (int'(off) > b) ? 0 : int'(off);
            if (m_cap && ((m_cnt + 1) % (b + 1)) != load) begin
                m_err = 1;
                if (m_er < 255) m_er++;
            end
            if (m_ev < 65535) m_ev++;
            m_cap = 1; m_cnt = load; m_active = 1;
        end else begin
            m_cnt = (m_cnt + 1) % (b + 1);
        end
        if (dis) m_active = 1;
        p1 = (hist.size() >= 1) ? hist[hist.size()-1] : 1'b0;
        p2 = (hist.size() >= 2) ? hist[hist.size()-2] : 1'b0;
        m_sedge = p1 && !p2;
        hist.push_back(v);
        if (hist.size() > 4) void'(hist.pop_front());
        #1;
    endtask

    task automatic apply_reset(input int b, input int o, input bit os, input bit ds);
        reset = 1'b1;
        sysref = 1'b0;
        beats = 8'(b); off = 8'(o); one = os; dis = ds;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (act_vec !== 13'd0) begin
            errors++;
            $display("FAIL reset_state got %h want 0", act_vec);
        end
    endtask

    task automatic test_free_run();
        apply_reset(3, 0, 0, 1);
        checks++;
        if (lmfc_counter !== 8'd0) begin
            errors++;
            $display("FAIL free_run_start counter got %0d want 0", lmfc_counter);
        end
        for (int i = 0; i < 16; i++) begin
            step(0);
            checks++;
            if (lmfc_counter !== 8'((i + 1) % 4) || lmfc_edge !== ((i + 1) % 4 == 0)
                || lmfc_clk !== ((i + 1) % 4 <= 1) || sysref_captured !== 1'b0) begin
                errors++;
                $display("FAIL free_run cyc%0d got cnt=%0d edge=%b clk=%b cap=%b want cnt=%0d",
                         i, lmfc_counter, lmfc_edge, lmfc_clk, sysref_captured, (i + 1) % 4);
            end
            checks++;
            if (act_vec !== exp_vec()) begin
                errors++;
                $display("FAIL free_run_model cyc%0d got %h want %h", i, act_vec, exp_vec());
            end
        end
    endtask

    task automatic test_first_capture();
        apply_reset(7, 2, 0, 0);
        for (int i = 0; i < 5; i++) step(0);
        step(1);
        step(0);
        checks++;
        if (sysref_edge !== 1'b1 || lmfc_edge !== 1'b0) begin
            errors++;
            $display("FAIL capture_sysref_edge got edge=%b lmfc_edge=%b want 1,0", sysref_edge, lmfc_edge);
        end
        step(0);
        checks++;
        if (lmfc_counter !== 8'd2 || sysref_captured !== 1'b1 || sysref_alignment_error !== 1'b0) begin
            errors++;
            $display("FAIL capture_load got cnt=%0d cap=%b err=%b want 2,1,0",
                     lmfc_counter, sysref_captured, sysref_alignment_error);
        end
        for (int i = 4; i <= 9; i++) begin
            step(0);
            checks++;
            if (lmfc_edge !== (i == 9) || act_vec !== exp_vec()) begin
                errors++;
                $display("FAIL capture_first_edge T+%0d got %h want %h", i, act_vec, exp_vec());
            end
        end
    endtask

    task automatic test_periodic();
        int prev;
        for (int i = 0; i < 7; i++) step(0);
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 8; i++) begin
                prev = int'(lmfc_counter);
                step(i == 0);
                checks++;
                if (lmfc_counter !== 8'((prev + 1) % 8) || sysref_alignment_error !== 1'b0
                    || act_vec !== exp_vec()) begin
                    errors++;
                    $display("FAIL periodic n%0d i%0d got %h want %h", n, i, act_vec, exp_vec());
                end
            end
        end
`ifdef JESD204_LMFC_SYSREF_STATS_EN
        checks++;
        if (sysref_event_count !== 16'(m_ev)) begin
            errors++;
            $display("FAIL periodic_events got %0d want %0d", sysref_event_count, m_ev);
        end
`endif
    endtask

    task automatic test_misaligned();
        step(1);
        for (int i = 0; i < 4; i++) step(0);
        step(1);
        step(0);
        step(0);
        checks++;
        if (lmfc_counter !== 8'd2 || sysref_alignment_error !== 1'b1) begin
            errors++;
            $display("FAIL misaligned_reload got cnt=%0d err=%b want 2,1", lmfc_counter, sysref_alignment_error);
        end
        for (int i = 0; i < 20; i++) begin
            step(0);
            checks++;
            if (sysref_alignment_error !== 1'b1 || act_vec !== exp_vec()) begin
                errors++;
                $display("FAIL misaligned_sticky cyc%0d got %h want %h", i, act_vec, exp_vec());
            end
        end
`ifdef JESD204_LMFC_SYSREF_STATS_EN
        checks++;
        if (sysref_error_count !== 8'd1) begin
            errors++;
            $display("FAIL misaligned_errcount got %0d want 1", sysref_error_count);
        end
`endif
    endtask

    task automatic test_oneshot();
        int prev;
        apply_reset(7, 2, 1, 0);
        for (int i = 0; i < 3; i++) step(0);
        step(1);
        step(0);
        step(0);
        for (int i = 0; i < 4; i++) step(i == 2);
        for (int i = 0; i < 12; i++) begin
            prev = int'(lmfc_counter);
            step(0);
            checks++;
            if (lmfc_counter !== 8'((prev + 1) % 8) || sysref_alignment_error !== 1'b0
                || sysref_captured !== 1'b1 || act_vec !== exp_vec()) begin
                errors++;
                $display("FAIL oneshot cyc%0d got %h want %h", i, act_vec, exp_vec());
            end
        end
`ifdef JESD204_LMFC_SYSREF_STATS_EN
        checks++;
        if (sysref_event_count !== 16'd1) begin
            errors++;
            $display("FAIL oneshot_events got %0d want 1", sysref_event_count);
        end
`endif
    endtask

    task automatic test_offset_clamp();
        apply_reset(7, 9, 0, 0);
        step(0);
        step(0);
        step(1);
        step(0);
        step(0);
        checks++;
        if (lmfc_counter !== 8'd0 || lmfc_edge !== 1'b1 || sysref_captured !== 1'b1) begin
            errors++;
            $display("FAIL offset_clamp got cnt=%0d edge=%b cap=%b want 0,1,1",
                     lmfc_counter, lmfc_edge, sysref_captured);
        end
    endtask

    task automatic test_beats_zero();
        apply_reset(0, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            step(0);
            checks++;
            if (lmfc_edge !== 1'b1 || lmfc_clk !== 1'b1 || lmfc_counter !== 8'd0) begin
                errors++;
                $display("FAIL beats_zero cyc%0d got edge=%b clk=%b cnt=%0d want 1,1,0",
                         i, lmfc_edge, lmfc_clk, lmfc_counter);
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset(7, 2, 0, 0);
        step(1);
        for (int i = 0; i < 5; i++) step(0);
        reset = 1'b1;
        #1;
        checks++;
        if (act_vec !== 13'd0) begin
            errors++;
            $display("FAIL reset_mid got %h want 0", act_vec);
        end
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        step(1);
        step(0);
        reset = 1'b1;
        #1;
        checks++;
        if (act_vec !== 13'd0) begin
            errors++;
            $display("FAIL reset_pending got %h want 0", act_vec);
        end
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        for (int i = 0; i < 12; i++) begin
            step(0);
            checks++;
            if (lmfc_edge !== 1'b0 || sysref_captured !== 1'b0 || act_vec !== exp_vec()) begin
                errors++;
                $display("FAIL reset_discard cyc%0d got %h want %h", i, act_vec, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        bit v;
        for (int r = 0; r < 8; r++) begin
            apply_reset(int'($urandom_range(0, 12)), int'($urandom_range(0, 15)),
                        bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
            v = 1'b0;
            for (int i = 0; i < 250; i++) begin
                if ($urandom_range(0, 4) == 0) v = ~v;
                step(v);
                checks++;
                if (act_vec !== exp_vec()) begin
                    errors++;
                    $display("FAIL random r%0d cyc%0d got %h want %h", r, i, act_vec, exp_vec());
                end
            end
`ifdef JESD204_LMFC_SYSREF_STATS_EN
            checks++;
            if (sysref_event_count !== 16'(m_ev) || sysref_error_count !== 8'(m_er)) begin
                errors++;
                $display("FAIL random_stats r%0d got %0d/%0d want %0d/%0d", r,
                         sysref_event_count, sysref_error_count, m_ev, m_er);
            end
`endif
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_free_run();
        test_first_capture();
        test_periodic();
        test_misaligned();
        test_oneshot();
        test_offset_clamp();
        test_beats_zero();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got no completion want finish");
        $fatal(1, "timeout");
    end
endmodule
